// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared defaults for the VGA circle renderer and the circle-entry record.
//   COORD_W_DEF  : width of pixel coordinates and circle geometry
//   COLOR_W_DEF  : bits per colour component
//   V_ACTIVE_DEF : active lines, used to flip y into Cartesian orientation
//   circle_entry_t : {en, cx, cy, r, color} at the default widths
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned COORD_W_DEF  = 10;
    localparam int unsigned COLOR_W_DEF  = 4;
    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic                     en;
        logic [COORD_W_DEF-1:0]   cx;
        logic [COORD_W_DEF-1:0]   cy;
        logic [COORD_W_DEF-1:0]   r;
        logic [3*COLOR_W_DEF-1:0] color;
    } circle_entry_t;

endpackage

// File: rtl/circle_dist_pipe.sv
// -----------------------------------------------------------------------------
// circle_dist_pipe
// Three-stage inside-circle test for one channel.
//   S1: signed dx = x - cx, dy = y - cy
//   S2: dx^2, dy^2
//   S3: inside = en && (dx^2 + dy^2 <= r^2), full width, no overflow
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_x, i_y        : Cartesian pixel coordinate
//   i_cx, i_cy, i_r : circle centre and radius (active entry)
//   i_en            : channel enable (active entry)
//   o_inside        : registered S3 result
// -----------------------------------------------------------------------------
module circle_dist_pipe
    import vga_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_cx,
    input  logic [COORD_W-1:0] i_cy,
    input  logic [COORD_W-1:0] i_r,
    input  logic               i_en,
    output logic               o_inside
);

    localparam int unsigned DW   = COORD_W + 1;
    localparam int unsigned SQW  = 2 * COORD_W + 2;
    localparam int unsigned SUMW = 2 * COORD_W + 3;

    logic signed [DW-1:0]  r_dx, r_dy;
    logic signed [SQW-1:0] w_dx_ext, w_dy_ext;
    logic [SQW-1:0]        r_dx2, r_dy2;
    logic [SUMW-1:0]       w_sum, w_r_ext, w_r2;
    logic                  r_inside;

    assign w_dx_ext = {{(SQW-DW){r_dx[DW-1]}}, r_dx};
    assign w_dy_ext = {{(SQW-DW){r_dy[DW-1]}}, r_dy};
    assign w_sum    = {1'b0, r_dx2} + {1'b0, r_dy2};
    assign w_r_ext  = {{(SUMW-COORD_W){1'b0}}, i_r};
    assign w_r2     = w_r_ext * w_r_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dx     <= '0;
            r_dy     <= '0;
            r_dx2    <= '0;
            r_dy2    <= '0;
            r_inside <= 1'b0;
        end else begin
            r_dx     <= $signed({1'b0, i_x}) - $signed({1'b0, i_cx});
            r_dy     <= $signed({1'b0, i_y}) - $signed({1'b0, i_cy});
            r_dx2    <= w_dx_ext * w_dx_ext;
            r_dy2    <= w_dy_ext * w_dy_ext;
            // Radius and enable are read live; entries only change on
            // frame_start, which arrives during blanking.
            r_inside <= i_en && (w_sum <= w_r2);
        end
    end

    assign o_inside = r_inside;

endmodule

// File: rtl/vga_multi_circle.sv
// -----------------------------------------------------------------------------
// vga_multi_circle
// Draws up to NUM_CIRCLES filled circles over a background colour.
// Configuration is written into shadow entries and promoted to the active
// set on frame_start, so a frame never shows a half-updated configuration.
// Fixed 4-cycle latency, one pixel per clock.
// Ports:
//   clk, rst_n              : pixel clock, asynchronous active-low reset
//   pos_h, pos_v, blank     : pixel position, high = active region
//   frame_start             : promotes shadow entries to active
//   cfg_we, cfg_idx, cfg_*  : shadow entry write port
//   red, green, blue        : registered colour
//   hit, hit_idx            : pixel inside an enabled circle, winning channel
// -----------------------------------------------------------------------------
module vga_multi_circle
    import vga_pkg::*;
#(
    parameter int unsigned           NUM_CIRCLES = 4,
    parameter int unsigned           COORD_W     = COORD_W_DEF,
    parameter int unsigned           COLOR_W     = COLOR_W_DEF,
    parameter int unsigned           V_ACTIVE    = V_ACTIVE_DEF,
    parameter logic [3*COLOR_W-1:0]  BG_COLOR    = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COORD_W-1:0]     pos_h,
    input  logic [COORD_W-1:0]     pos_v,
    input  logic                   blank,
    input  logic                   frame_start,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_idx,
    input  logic                   cfg_en,
    input  logic [COORD_W-1:0]     cfg_cx,
    input  logic [COORD_W-1:0]     cfg_cy,
    input  logic [COORD_W-1:0]     cfg_r,
    input  logic [3*COLOR_W-1:0]   cfg_color,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   hit,
    output logic [2:0]             hit_idx
);

    localparam int unsigned CW = 3 * COLOR_W;
    localparam logic [COORD_W-1:0] V_ACT = COORD_W'(V_ACTIVE);

    // Same shape as vga_pkg::circle_entry_t, sized by this instance.
    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic [COORD_W-1:0] r;
        logic [CW-1:0]      color;
    } entry_t;

    entry_t                 r_shadow [NUM_CIRCLES];
    entry_t                 r_active [NUM_CIRCLES];
    entry_t                 w_cfg;
    logic [COORD_W-1:0]     w_x, w_y;
    logic [2:0]             r_blank;  // blank aligned to S1, S2, S3
    logic [NUM_CIRCLES-1:0] w_inside;
    logic                   w_hit;
    logic [2:0]             w_idx;
    logic [CW-1:0]          w_color;
    logic [CW-1:0]          r_rgb;
    logic                   r_hit;
    logic [2:0]             r_hit_idx;

    assign w_x   = pos_h;
    assign w_y   = V_ACT - pos_v;  // wraps modulo 2^COORD_W
    assign w_cfg = '{en: cfg_en, cx: cfg_cx, cy: cfg_cy, r: cfg_r, color: cfg_color};

    // Active copies the pre-edge shadow, so a write coinciding with
    // frame_start waits for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CIRCLES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CIRCLES; i++) begin
                if (frame_start) r_active[i] <= r_shadow[i];
                if (cfg_we && cfg_idx == 3'(i)) r_shadow[i] <= w_cfg;
            end
        end
    end

    for (genvar g = 0; g < NUM_CIRCLES; g++) begin : g_chan
        circle_dist_pipe #(
            .COORD_W(COORD_W)
        ) u_pipe (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_x     (w_x),
            .i_y     (w_y),
            .i_cx    (r_active[g].cx),
            .i_cy    (r_active[g].cy),
            .i_r     (r_active[g].r),
            .i_en    (r_active[g].en),
            .o_inside(w_inside[g])
        );
    end

    // Scan high to low so the lowest-index hit is the last assignment.
    always_comb begin
        w_hit   = 1'b0;
        w_idx   = '0;
        w_color = '0;
        for (int i = int'(NUM_CIRCLES) - 1; i >= 0; i--) begin
            if (w_inside[i]) begin
                w_hit   = 1'b1;
                w_idx   = 3'(i);
                w_color = r_active[i].color;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank   <= '0;
            r_rgb     <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            r_blank <= {r_blank[1:0], blank};
            if (!r_blank[2]) begin
                r_rgb     <= '0;
                r_hit     <= 1'b0;
                r_hit_idx <= '0;
            end else if (w_hit) begin
                r_rgb     <= w_color;
                r_hit     <= 1'b1;
                r_hit_idx <= w_idx;
            end else begin
                r_rgb     <= BG_COLOR;
                r_hit     <= 1'b0;
                r_hit_idx <= '0;
            end
        end
    end

    assign red     = r_rgb[CW-1 -: COLOR_W];
    assign green   = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign blue    = r_rgb[COLOR_W-1:0];
    assign hit     = r_hit;
    assign hit_idx = r_hit_idx;

endmodule
